// File: rtl/mdu_unit.sv
// Multiply/divide unit holding the HI/LO registers, with fixed multi-cycle latency signalled by busy.
// Optional MADD/MADDU (ops 6/7) are enabled by defining MDU_MADD_EN.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [63:0]        pend, pend_d;
  logic               pend_wr, pend_wr_d;
  logic               busy_d, done_d;
  logic [31:0]        hi_d, lo_d;

  // Operand arithmetic, evaluated on the issue cycle
  logic signed [63:0] rs_sx, rt_sx;
  logic [63:0]        prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] dvd_s, dvs_s;
  logic [31:0]        dvs_u, quo_s, rem_s, quo_u, rem_u;

  assign rs_sx    = {{32{rs_data[31]}}, rs_data};
  assign rt_sx    = {{32{rt_data[31]}}, rt_data};
  assign prod_s   = rs_sx * rt_sx;
  assign prod_u   = {32'd0, rs_data} * {32'd0, rt_data};
  assign div_zero = (rt_data == 32'd0);
  assign div_ovf  = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
  // Divisor forced to 1 on zero/overflow so the dividers never see an undefined case
  assign dvd_s    = rs_data;
  assign dvs_s    = (div_zero || div_ovf) ? 32'sd1 : rt_data;
  assign dvs_u    = div_zero ? 32'd1 : rt_data;
  assign quo_s    = div_ovf ? 32'h8000_0000 : 32'(dvd_s / dvs_s);
  assign rem_s    = div_ovf ? 32'd0 : 32'(dvd_s % dvs_s);
  assign quo_u    = rs_data / dvs_u;
  assign rem_u    = rs_data % dvs_u;

`ifdef MDU_MADD_EN
  logic [63:0] macc_s, macc_u;
  assign macc_s = {hi, lo} + prod_s;
  assign macc_u = {hi, lo} + prod_u;
`endif

  // Op decode: timed ops, their latency, result and whether HI/LO get written
  logic             timed;
  logic [CNT_W-1:0] lat;
  logic [63:0]      res;
  logic             wr;

  always_comb begin
    timed = 1'b0;
    lat   = CNT_W'(MULT_CYCLES);
    res   = 64'd0;
    wr    = 1'b1;
    case (op)
      OP_MULT:  begin timed = 1'b1; res = prod_s; end
      OP_MULTU: begin timed = 1'b1; res = prod_u; end
      OP_DIV:   begin timed = 1'b1; lat = CNT_W'(DIV_CYCLES); wr = !div_zero; res = {rem_s, quo_s}; end
      OP_DIVU:  begin timed = 1'b1; lat = CNT_W'(DIV_CYCLES); wr = !div_zero; res = {rem_u, quo_u}; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin timed = 1'b1; res = macc_s; end
      OP_MADDU: begin timed = 1'b1; res = macc_u; end
`endif
      default:  ;
    endcase
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pend_d    = pend;
    pend_wr_d = pend_wr;
    busy_d    = busy;
    done_d    = 1'b0;
    hi_d      = hi;
    lo_d      = lo;
    case (state)
      IDLE: begin
        if (start) begin
          if (timed) begin
            state_d   = BUSY;
            cnt_d     = lat;
            busy_d    = 1'b1;
            pend_d    = res;
            pend_wr_d = wr;
          end else if (op == OP_MTHI) begin
            hi_d = rs_data;
          end else if (op == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (pend_wr) begin
            hi_d = pend[63:32];
            lo_d = pend[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      pend    <= pend_d;
      pend_wr <= pend_wr_d;
      busy    <= busy_d;
      done    <= done_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: transaction-level model predicts HI/LO, busy and done.
module tb_mdu_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Architectural model: visible HI/LO, remaining busy cycles, expected results queue
  int          m_left;
  bit          m_done;
  logic [31:0] vis_hi, vis_lo;
  logic [63:0] pend;
  logic [63:0] exq[$];

  function automatic void model_issue(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    bit          wr, timed;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    timed = 1; wr = 1; n = MULT_N; p = 64'd0;
    case (o)
      3'd0: p = 64'(sa * sb);
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin n = DIV_N; wr = (b != 0); if (wr) p = {32'(sa % sb), 32'(sa / sb)}; end
      3'd3: begin n = DIV_N; wr = (b != 0); if (wr) p = {a % b, a / b}; end
      3'd4: begin timed = 0; vis_hi = a; end
      3'd5: begin timed = 0; vis_lo = a; end
`ifdef MDU_MADD_EN
      3'd6: p = {vis_hi, vis_lo} + 64'(sa * sb);
      3'd7: p = {vis_hi, vis_lo} + {32'd0, a} * {32'd0, b};
`else
      default: timed = 0;
`endif
    endcase
    if (timed) begin
      if (!wr) p = {vis_hi, vis_lo};
      pend = p;
      exq.push_back(p);
      m_left = n;
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0;
      m_done = 0;
      vis_hi = 32'd0;
      vis_lo = 32'd0;
      exq.delete();
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {vis_hi, vis_lo} = pend;
          m_done = 1;
        end
      end else if (start) begin
        model_issue(op, rs_data, rt_data);
      end
    end
  end

  // Monitor: compare every cycle, pop the scoreboard on each done pulse
  always @(negedge clk) begin
    logic [63:0] e;
    chk("busy", 64'(busy), 64'(m_left != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("hi", 64'(hi), 64'(vis_hi));
    chk("lo", 64'(lo), 64'(vis_lo));
    if (done === 1'b1) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 expected no pending op at %0t", $time);
      end else begin
        e = exq.pop_front();
        chk("done_hilo", {hi, lo}, e);
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
    idle(3);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    idle(1);

    drive(3'd0, 32'hFFFF_FFFF, 32'h2);
    idle(5);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mult_done", 64'(done), 64'd1);
    idle(1);
    chk("mult_done_off", 64'(done), 64'd0);

    drive(3'd1, 32'hFFFF_FFFF, 32'h2);
    idle(5);
    chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    drive(3'd2, 32'hFFFF_FFF9, 32'h2);
    idle(10);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    drive(3'd3, 32'd7, 32'd0);
    idle(10);
    chk("divu0_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("divu0_done", 64'(done), 64'd1);

    drive(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    drive(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'd0);

    drive(3'd0, 32'd3, 32'd4);
    idle(1);
    drive(3'd3, 32'd100, 32'd7);
    idle(10);
    chk("ignore_hilo", {hi, lo}, 64'h0000_0000_0000_000C);

    // Abort an in-flight multiply with an async reset mid-cycle
    drive(3'd0, 32'd3, 32'd4);
    idle(1);
    #3 reset = 1'b0;
    #2;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    idle(8);
    chk("abort_no_result", {hi, lo}, 64'd0);

    drive(3'd4, 32'd0, 32'd0);
    drive(3'd5, 32'hFFFF_FFFF, 32'd0);
    drive(3'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    chk("maddu_busy", 64'(busy), 64'd1);
    idle(5);
    chk("maddu_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
`else
    chk("op7_busy", 64'(busy), 64'd0);
    idle(5);
    chk("op7_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    for (int i = 0; i < 80; i++) begin
      drive(3'($urandom_range(0, 7)), pick(), pick());
      idle(int'($urandom_range(0, 12)));
    end

    idle(15);
    chk("queue_drained", 64'(exq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit for the MIPS datapath; sits directly downstream of the general register file.
- Consumes the GRF read ports (RD1 as rs operand, RD2 as rt operand).
- Holds the architectural HI/LO registers and models fixed multi-cycle latency through a busy flag. Issue logic stalls on that flag.

Parameters:
- MULT_CYCLES, 5: cycles busy for multiply-class ops.
- DIV_CYCLES, 10: cycles busy for divide-class ops.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  issue strobe for op this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 see Optional Feature
- rs_data  input  32  operand A (from GRF RD1)
- rt_data  input  32  operand B (from GRF RD2)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse: HI/LO just updated by a timed op
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset=0, async): state IDLE, counter=0, hi=0, lo=0, busy=0, done=0, pending results cleared.
  - Reset mid-operation aborts the op. No HI/LO update follows.
- FSM has two states, IDLE and BUSY.
- IDLE, start=1, op in {0..3}:
  - Latch operands and the computed 64-bit result into pending_hi/pending_lo at edge k.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES); go to BUSY.
  - busy=1 during cycles k+1 .. k+N.
- BUSY:
  - Counter decrements each edge.
  - At the edge where the counter reaches 0 (edge k+N): hi<=pending_hi, lo<=pending_lo, busy<=0, done<=1 for one cycle, state IDLE.
- IDLE, start=1, op=4 (MTHI) or 5 (MTLO): hi or lo <= rs_data at the next edge.
  - busy stays 0; done stays 0.
- start while BUSY: ignored entirely, with no effect on the op in flight. The pipeline is required not to do this; the ignore rule is the defined fallback.
- start in the same cycle busy falls: the unit is already IDLE, so the new op is accepted.
- Reserved op with start=1: no-op, no busy.
- Arithmetic:
  - MULT: signed 32x32->64, hi=upper, lo=lower.
  - MULTU: unsigned 32x32->64.
  - DIV: lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (DIV or DIVU): still busy N cycles and done pulses, but hi/lo are left unchanged.
- hi/lo outputs are register values only. MFHI/MFLO read them directly; there is no bypass of pending results.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 6 = MADD: {hi,lo} <= {hi,lo} + signed(rs*rt), computed from hi/lo values at issue.
  - op 7 = MADDU: same with an unsigned product.
  - Both use MULT_CYCLES latency, busy and done as for multiply. 64-bit sum wraps modulo 2^64.
- Undefined: ops 6/7 are reserved no-ops.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; done pulses once.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> hi/lo unchanged, done still pulses at cycle 10.
- MTHI rs=0x12345678 -> hi=0x12345678 next cycle, busy never asserts. Then MULT 3*4 issued, and DIVU 100/7 issued with start 2 cycles later -> DIVU ignored; hi=0, lo=0x0000000C.
- MULT 3*4 issued, reset pulsed low at cycle 2 of busy -> busy=0, hi=lo=0 immediately; no done pulse afterwards.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=0x00000001, lo=0x00000000 after 5 cycles. Without the macro, op 7 leaves hi/lo unchanged and busy=0.
